// File: rtl/cond_logic.sv
// Conditional-execution unit: evaluates the instruction condition field against
// the architectural NZCV flags, qualifies control requests and counts squashes.
module cond_logic (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [3:0]  Cond,
   input  logic [1:0]  PCS,
   input  logic        RegW,
   input  logic        MemW,
   input  logic [1:0]  FlagW,
   input  logic        NoWrite,
   input  logic [3:0]  ALUFlags,
   output logic [1:0]  PCSrc,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic        N,
   output logic        Z,
   output logic        C,
   output logic        V,
   output logic        CondEx,
   output logic [15:0] SkipCount
);

   logic [3:0]  flags_r;
   logic [3:0]  flags_eff_s;
   logic        exec_s;
   logic [15:0] skip_r;

   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      logic pass;
      {n, z, c, v} = nzcv;
      case (cond)
         4'b0000: pass = z;
         4'b0001: pass = ~z;
         4'b0010: pass = c;
         4'b0011: pass = ~c;
         4'b0100: pass = n;
         4'b0101: pass = ~n;
         4'b0110: pass = v;
         4'b0111: pass = ~v;
         4'b1000: pass = c & ~z;
         4'b1001: pass = ~c | z;
         4'b1010: pass = (n == v);
         4'b1011: pass = (n != v);
         4'b1100: pass = ~z & (n == v);
         4'b1101: pass = z | (n != v);
         4'b1110: pass = 1'b1;
         default: pass = 1'b0;
      endcase
      return pass;
   endfunction

   // While reset is held the condition sees the flags it is about to be cleared to.
   always_comb begin
      flags_eff_s = flags_r;
      if (rst) begin
         flags_eff_s = 4'b0000;
      end else begin
         flags_eff_s = flags_r;
      end
   end

   // Condition evaluation and qualification of the control requests.
   always_comb begin
      CondEx   = cond_pass(Cond, flags_eff_s);
      exec_s   = en & CondEx;
      PCSrc    = 2'b00;
      if (exec_s) begin
         PCSrc = PCS;
      end else begin
         PCSrc = 2'b00;
      end
      RegWrite = RegW & exec_s & ~NoWrite;
      MemWrite = MemW & exec_s;
   end

   // Flag register: N,Z and C,V groups load independently on executed instructions.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_r <= 4'b0000;
      end else begin
         if (exec_s && FlagW[1]) begin
            flags_r[3:2] <= ALUFlags[3:2];
         end else begin
            flags_r[3:2] <= flags_r[3:2];
         end
         if (exec_s && FlagW[0]) begin
            flags_r[1:0] <= ALUFlags[1:0];
         end else begin
            flags_r[1:0] <= flags_r[1:0];
         end
      end
   end

   // Saturating count of valid instructions whose condition failed.
   always_ff @(posedge clk) begin
      if (rst) begin
         skip_r <= 16'h0000;
      end else if (en && !CondEx && (skip_r != 16'hFFFF)) begin
         skip_r <= skip_r + 16'd1;
      end else begin
         skip_r <= skip_r;
      end
   end

   assign {N, Z, C, V} = flags_r;
   assign SkipCount    = skip_r;

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 en  input  1  instruction-valid / not-stalled; 0 = current cycle is a bubble.
REQ-004 Cond  input  4  instruction bits [31:28], the condition field.
REQ-005 PCS  input  2  unconditioned PC-source request from the control unit.
REQ-006 RegW  input  1  unconditioned register-write request.
REQ-007 MemW  input  1  unconditioned memory-write request.
REQ-008 FlagW  input  2  flag-write request: [1] = N,Z; [0] = C,V.
REQ-009 NoWrite  input  1  compare-class op (CMP/CMN/TST/TEQ); suppresses register write.
REQ-010 ALUFlags  input  4  {N,Z,C,V} produced by the ALU this cycle.
REQ-011 PCSrc  output  2  conditioned PC source.
REQ-012 RegWrite  output  1  conditioned register write.
REQ-013 MemWrite  output  1  conditioned memory write.
REQ-014 N, Z, C, V  output  1 each  architectural flag register, fed back to the control unit.
REQ-015 CondEx  output  1  condition of the current instruction passes against the registered flags.
REQ-016 SkipCount  output  16  debug counter of squashed instructions.

Function
REQ-017 CondEx SHALL be combinational from Cond and the registered N,Z,C,V: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 reserved 0.
REQ-018 Qualified execute: Exec = en & CondEx.
REQ-019 PCSrc SHALL equal PCS when Exec = 1, else 2'b00.
REQ-020 RegWrite SHALL equal RegW & Exec & !NoWrite.
REQ-021 MemWrite SHALL equal MemW & Exec.
REQ-022 On a rising clk edge with Exec = 1 and FlagW[1] = 1, N,Z SHALL load ALUFlags[3:2].
REQ-023 On a rising clk edge with Exec = 1 and FlagW[0] = 1, C,V SHALL load ALUFlags[1:0].
REQ-024 Flag groups SHALL update independently; a group whose FlagW bit is 0 holds its value.
REQ-025 Flags SHALL NOT change when Exec = 0, regardless of FlagW.
REQ-026 CondEx SHALL always use pre-edge flags; a flag update is first visible to the next instruction (one-cycle latency, no bypass).
REQ-027 SkipCount SHALL increment by 1 on each edge with en = 1 and CondEx = 0.
REQ-028 SkipCount SHALL saturate at 16'hFFFF; further squashes leave it at 16'hFFFF.
REQ-029 en = 0 cycles SHALL neither update flags nor change SkipCount.
REQ-030 Combinational outputs SHALL have no dependence on clk other than through the flag register; no combinational loop from ALUFlags to CondEx.

Reset
REQ-031 rst = 1 at a rising edge SHALL clear N,Z,C,V to 0 and SkipCount to 0.
REQ-032 rst SHALL take priority over a simultaneous flag update or count increment.
REQ-033 During rst, combinational outputs SHALL follow REQ-017..REQ-021 using the post-reset flags 0000.
REQ-034 Reset asserted mid-sequence SHALL discard all pending state; the first post-reset instruction evaluates against flags 0000.

Verification
REQ-035 After reset, Cond=0000 (EQ), en=1, RegW=1 -> CondEx=0, RegWrite=0, SkipCount=1 after the edge.
REQ-036 SUBS with en=1, Cond=1110, FlagW=11, ALUFlags=0110 -> after the edge N=0, Z=1, C=1, V=0; next cycle BEQ (Cond=0000, PCS=01) -> PCSrc=01.
REQ-037 Flags N=1, V=0; Cond=1010 (GE), FlagW=11, ALUFlags=0000 -> CondEx=0, flags unchanged, MemWrite=0 with MemW=1.
REQ-038 Flags Z=0, C=0; FlagW=10, ALUFlags=0111, Cond=1110 -> N,Z become 0,1; C,V stay 0,0. CMP with NoWrite=1, RegW=1 -> RegWrite=0.
REQ-039 Preload SkipCount to 16'hFFFE via 65534 squashed cycles; two more squashes -> 16'hFFFF and held; en=0 cycles do not change the count.
REQ-040 rst=1 on the same edge as en=1, FlagW=11, ALUFlags=1111 -> flags 0000, SkipCount 0.
